uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_tick.sv | 28 ++
 rtl/uart_tx.sv | 178 +++++++++++++++++
 tb/tb_uart_tx.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, 8N1 frame constants and the
// bit-period derivation. The receiver uses the same package.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  // Bit counter covers whichever of the data or stop phase is longer.
  localparam int BIT_CNT_W = (DATA_BITS > STOP_BITS) ? $clog2(DATA_BITS) : $clog2(STOP_BITS + 1);

  function automatic int ticks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: pulses bit_done for one cycle on the last clock of each
// bit period. clear holds it at zero so a new frame starts on a full period.
module uart_baud_tick #(
  parameter int TICKS_PER_BIT = 104
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_done
);

  localparam int CNT_W = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(TICKS_PER_BIT - 1);

  logic [CNT_W-1:0] tick_cnt;

  assign bit_done = !clear && (tick_cnt == LAST_TICK);

  // Wraps to zero on bit_done, so it never passes LAST_TICK inside a bit.
  always_ff @(posedge clk) begin
    if (reset || clear || bit_done) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-byte holding register ahead of the shift
// register, CTS flow control sampled only at frame start, registered tx/busy.
module uart_tx
  import uart_pkg::*;
#(
  parameter int BAUD_RATE = 115200,
  parameter int CLK_FREQ  = 12000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 data_valid,
  output logic                 data_ready,
  input  logic                 cts,
  output logic                 tx,
  output logic                 busy
);

  localparam int TICKS_PER_BIT = ticks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam logic [BIT_CNT_W-1:0] LAST_DATA_BIT = BIT_CNT_W'(DATA_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_STOP_BIT = BIT_CNT_W'(STOP_BITS - 1);

  uart_state_t state_q;
  uart_state_t state_d;

  logic                 cts_meta;
  logic                 cts_s;
  logic                 hold_full;
  logic [DATA_BITS-1:0] hold_data;
  logic [DATA_BITS-1:0] shift_q;
  logic [BIT_CNT_W-1:0] bit_cnt;

  logic bit_done;
  logic tick_clear;
  logic accept;
  logic frame_ok;
  logic load_frame;
  logic shift_bit;
  logic bit_cnt_clear;
  logic bit_cnt_step;

  function automatic logic line_level(input uart_state_t st, input logic lsb);
    case (st)
      START:   line_level = 1'b0;
      DATA:    line_level = lsb;
      default: line_level = 1'b1;
    endcase
  endfunction

  assign data_ready = !hold_full;
  assign accept     = data_valid && data_ready;
  assign frame_ok   = hold_full && !cts_s;

  uart_baud_tick #(
    .TICKS_PER_BIT(TICKS_PER_BIT)
  ) u_baud_tick (
    .clk      (clk),
    .reset    (reset),
    .clear    (tick_clear),
    .bit_done (bit_done)
  );

  // cts is asynchronous to clk; resets to "not clear to send".
  always_ff @(posedge clk) begin
    if (reset) begin
      cts_meta <= 1'b1;
      cts_s    <= 1'b1;
    end else begin
      cts_meta <= cts;
      cts_s    <= cts_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    tick_clear    = 1'b0;
    load_frame    = 1'b0;
    shift_bit     = 1'b0;
    bit_cnt_clear = 1'b0;
    bit_cnt_step  = 1'b0;
    case (state_q)
      IDLE: begin
        tick_clear = 1'b1;
        if (frame_ok) begin
          state_d       = START;
          load_frame    = 1'b1;
          bit_cnt_clear = 1'b1;
        end
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_bit = 1'b1;
          if (bit_cnt == LAST_DATA_BIT) begin
            state_d       = STOP;
            bit_cnt_clear = 1'b1;
          end else begin
            bit_cnt_step = 1'b1;
          end
        end
      end
      STOP: begin
        // Chain straight into the next frame when a byte is waiting.
        if (bit_done) begin
          if (bit_cnt != LAST_STOP_BIT) begin
            bit_cnt_step = 1'b1;
          end else if (frame_ok) begin
            state_d       = START;
            load_frame    = 1'b1;
            bit_cnt_clear = 1'b1;
          end else begin
            state_d       = IDLE;
            bit_cnt_clear = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt <= '0;
    end else if (bit_cnt_clear) begin
      bit_cnt <= '0;
    end else if (bit_cnt_step) begin
      bit_cnt <= bit_cnt + BIT_CNT_W'(1);
    end
  end

  // An accept and a transfer cannot coincide (ready means empty); accept wins regardless.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_full <= 1'b0;
    end else if (accept) begin
      hold_full <= 1'b1;
    end else if (load_frame) begin
      hold_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      hold_data <= data_in;
    end
    if (load_frame) begin
      shift_q <= hold_data;
    end else if (shift_bit) begin
      shift_q <= shift_q >> 1;
    end
  end

  // Line stage: tx and busy trail the FSM by one clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx   <= 1'b1;
      busy <= 1'b0;
    end else begin
      tx   <= line_level(state_q, shift_q[0]);
      busy <= (state_q != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with a frame-level reference model checked every cycle.
module tb_uart_tx;

  localparam longint TPB   = 104;
  localparam longint FRAME = 10 * TPB;

  logic       clk;
  logic       reset;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       cts;
  logic       tx;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;

  localparam bit A5_SLOTS [0:8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  uart_tx #(
    .BAUD_RATE(115200),
    .CLK_FREQ (12000000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .cts        (cts),
    .tx         (tx),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  longint     cyc = 0;
  bit         live = 1'b0;
  bit         m_hold_full;
  logic [7:0] m_hold;
  bit         m_cts_d1;
  bit         m_cts_d2;
  bit         m_frame_on;
  longint     m_start;
  logic [7:0] m_byte;
  logic       exp_tx;
  logic       exp_busy;
  logic       exp_ready;
  bit         m_accept;
  bit         m_launch;
  int         m_slot;

  task automatic chk(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b (edge %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int slot);
    logic [9:0] frame;
    logic [3:0] idx;
    frame = {1'b1, b, 1'b0};
    idx   = slot[3:0];
    return frame[idx];
  endfunction

  // Frame-level model: a byte leaves the holding slot when cts (two edges late)
  // is low and its start bit would not overlap the previous frame.
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      live        = 1'b1;
      m_hold_full = 1'b0;
      m_cts_d1    = 1'b1;
      m_cts_d2    = 1'b1;
      m_frame_on  = 1'b0;
      exp_tx      = 1'b1;
      exp_busy    = 1'b0;
      exp_ready   = 1'b1;
    end else if (live) begin
      m_accept = data_valid && !m_hold_full;
      m_launch = m_hold_full && !m_cts_d2 && (!m_frame_on || (cyc + 1 >= m_start + FRAME));
      if (m_frame_on && cyc >= m_start && cyc < m_start + FRAME) begin
        m_slot   = int'((cyc - m_start) / TPB);
        exp_tx   = frame_bit(m_byte, m_slot);
        exp_busy = 1'b1;
      end else begin
        exp_tx   = 1'b1;
        exp_busy = 1'b0;
      end
      if (m_launch) begin
        m_frame_on = 1'b1;
        m_start    = cyc + 1;
        m_byte     = m_hold;
      end
      if (m_accept) begin
        m_hold_full = 1'b1;
        m_hold      = data_in;
      end else if (m_launch) begin
        m_hold_full = 1'b0;
      end
      m_cts_d2  = m_cts_d1;
      m_cts_d1  = cts;
      exp_ready = !m_hold_full;
    end
    #1;
    if (live) begin
      chk("model_tx", tx, exp_tx);
      chk("model_busy", busy, exp_busy);
      chk("model_ready", data_ready, exp_ready);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset      = 1'b1;
    data_valid = 1'b0;
    data_in    = 8'h00;
    cts        = 1'b0;
    tick(3);
    chk("reset_tx", tx, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_ready", data_ready, 1'b1);
    reset = 1'b0;
    tick(5);

    // Single 0xA5 frame.
    data_in = 8'hA5; data_valid = 1'b1; tick(1); data_valid = 1'b0;
    chk("a5_ready_held", data_ready, 1'b0);
    tick(1); chk("a5_tx_n1", tx, 1'b1);
    tick(1); chk("a5_start_n2", tx, 1'b0); chk("a5_busy", busy, 1'b1);
    for (int i = 0; i < 9; i++) begin
      tick(104);
      chk($sformatf("a5_slot%0d", i + 1), tx, A5_SLOTS[i]);
    end
    tick(103); chk("a5_last_stop_tx", tx, 1'b1); chk("a5_last_stop_busy", busy, 1'b1);
    tick(1); chk("a5_done_busy", busy, 1'b0); chk("a5_done_tx", tx, 1'b1);

    // Back-to-back 0x55, 0x0F.
    tick(5);
    data_in = 8'h55; data_valid = 1'b1; tick(1);
    data_in = 8'h0F; tick(1);
    chk("b2b_ready_after_transfer", data_ready, 1'b1);
    tick(1); data_valid = 1'b0;
    chk("b2b_second_held", data_ready, 1'b0); chk("b2b_start1", tx, 1'b0);
    tick(1039); chk("b2b_stop1_tx", tx, 1'b1); chk("b2b_stop1_busy", busy, 1'b1);
    tick(1); chk("b2b_start2_tx", tx, 1'b0); chk("b2b_start2_busy", busy, 1'b1);
    chk("b2b_ready_after_second", data_ready, 1'b1);
    tick(104); chk("b2b_0f_bit0", tx, 1'b1);
    tick(936); chk("b2b_done_busy", busy, 1'b0); chk("b2b_done_tx", tx, 1'b1);

    // 0x3C held by cts.
    tick(5); cts = 1'b1; tick(3);
    data_in = 8'h3C; data_valid = 1'b1; tick(1); data_valid = 1'b0;
    chk("cts_ready_held", data_ready, 1'b0);
    tick(5000);
    chk("cts_hold_tx", tx, 1'b1); chk("cts_hold_ready", data_ready, 1'b0); chk("cts_hold_busy", busy, 1'b0);
    cts = 1'b0; tick(3); chk("cts_release_m2", tx, 1'b1);
    tick(1); chk("cts_release_start", tx, 1'b0); chk("cts_release_busy", busy, 1'b1);
    tick(1045);

    // cts raised during bit 3 of 0xFF, 0x12 waiting.
    data_in = 8'hFF; data_valid = 1'b1; tick(1);
    data_in = 8'h12; tick(2); data_valid = 1'b0;
    chk("ff_start", tx, 1'b0);
    tick(450); cts = 1'b1;
    tick(450); chk("ff_bit7", tx, 1'b1);
    tick(139); chk("ff_stop_tx", tx, 1'b1); chk("ff_stop_busy", busy, 1'b1);
    tick(1); chk("ff_done_busy", busy, 1'b0); chk("ff_done_tx", tx, 1'b1);
    tick(200); chk("ff_wait_tx", tx, 1'b1); chk("ff_wait_ready", data_ready, 1'b0); chk("ff_wait_busy", busy, 1'b0);
    cts = 1'b0; tick(3); chk("x12_m2", tx, 1'b1);
    tick(1); chk("x12_start", tx, 1'b0);
    tick(1045);

    // Reset during bit 5 of 0x81 with 0x42 held, valid asserted with reset.
    data_in = 8'h81; data_valid = 1'b1; tick(1);
    data_in = 8'h42; tick(2); data_valid = 1'b0;
    tick(650);
    chk("x81_bit5", tx, 1'b0); chk("x81_held", data_ready, 1'b0);
    reset = 1'b1; data_valid = 1'b1; data_in = 8'h77; tick(1);
    chk("rst_mid_tx", tx, 1'b1); chk("rst_mid_busy", busy, 1'b0); chk("rst_mid_ready", data_ready, 1'b1);
    reset = 1'b0; data_valid = 1'b0;
    tick(1200);
    chk("rst_after_tx", tx, 1'b1); chk("rst_after_busy", busy, 1'b0); chk("rst_after_ready", data_ready, 1'b1);

    // 0x96 accepted, then valid held with changing data while not ready.
    cts = 1'b1; tick(3);
    data_in = 8'h96; data_valid = 1'b1; tick(1);
    for (int i = 0; i < 20; i++) begin
      data_in = 8'(i * 37 + 3);
      tick(1);
    end
    chk("x96_ready_low", data_ready, 1'b0); chk("x96_idle_tx", tx, 1'b1);
    data_valid = 1'b0; cts = 1'b0;
    tick(3); chk("x96_m2", tx, 1'b1);
    tick(1); chk("x96_start", tx, 1'b0);
    tick(156); chk("x96_bit0", tx, 1'b0);
    tick(104); chk("x96_bit1", tx, 1'b1);
    tick(104); chk("x96_bit2", tx, 1'b1);
    tick(700); chk("x96_done_busy", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
